svcoeff_loader: RTL and testbench
=================================

SVCOEFF_LOADER -- requirements
Module: svcoeff_loader

Interface
REQ-001 SHALL have parameter CWIDTH, default 9: signed coefficient width.
REQ-002 SHALL have parameter NCOEF, default 1088 (17 rows x 64): number of coefficients per load.
REQ-003 SHALL have port clk_proc, input, 1 bit: clock.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low; the clock is clk_proc.
REQ-005 SHALL have port start, input, 1 bit: load request pulse.
REQ-006 SHALL have port abort, input, 1 bit: terminate the current load.
REQ-007 SHALL have port in_fv, input, 1 bit: frame-valid of the pixel flow feeding the SVM.
REQ-008 SHALL have port coef_valid, input, 1 bit: coefficient stream valid.
REQ-009 SHALL have port coef_data, input, CWIDTH bits: signed coefficient.
REQ-010 SHALL have port coef_ready, output, 1 bit: coefficient stream ready.
REQ-011 SHALL have port addr_rel_o, output, 1 bit: register address (0 = SCR, 1 = LOAD).
REQ-012 SHALL have port wr_o, output, 1 bit: write strobe.
REQ-013 SHALL have port rd_o, output, 1 bit: read strobe.
REQ-014 SHALL have port datawr_o, output, 32 bits: write data.
REQ-015 SHALL have port datard_i, input, 32 bits: registered read data, valid the cycle after rd_o.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-018 SHALL have port error, output, 1 bit: sticky failure flag, cleared on an accepted start.
REQ-019 SHALL have port loaded_count, output, $clog2(NCOEF+1) bits: coefficients written in the current or last load.

Function
REQ-020 SHALL implement FSM states IDLE, ENABLE, STREAM, VERIFY_RD, VERIFY_CHK, DISABLE, DONE.
REQ-021 IDLE: start=1 with in_fv=0 SHALL move to ENABLE, clear error and clear loaded_count.
REQ-022 IDLE: start=1 with in_fv=1 SHALL be ignored, with no bus activity and no flag change.
REQ-023 SHALL register all bus outputs; wr_o, rd_o, addr_rel_o and datawr_o SHALL be 0 in every state other than those listed below.
REQ-024 ENABLE (exactly one cycle): wr_o=1, addr_rel_o=0, datawr_o=0x00000002 (SCR loadcoeff bit); next state STREAM.
REQ-025 STREAM: coef_ready SHALL be 1 (combinational from state) and 0 in all other states.
REQ-026 STREAM: a cycle with coef_valid&coef_ready is an accept; the next cycle SHALL drive wr_o=1, addr_rel_o=1, datawr_o = coef_data sign-extended to 32 bits.
REQ-027 Consecutive accepts SHALL give back-to-back writes, one per cycle; coef_valid=0 SHALL give wr_o=0 for that slot, with no timeout.
REQ-028 loaded_count SHALL increment by 1 per accept and SHALL saturate at NCOEF.
REQ-029 The NCOEF-th accept, at cycle T, SHALL move the FSM to VERIFY_RD; coef_ready SHALL be 0 from T+1.
REQ-030 Timing after the last accept at T: last LOAD write at T+1; VERIFY_RD drives rd_o=1, addr_rel_o=1 at T+2; VERIFY_CHK samples datard_i at T+3.
REQ-031 VERIFY_CHK: datard_i not equal to the last written sign-extended coefficient SHALL set error; the FSM SHALL go to DISABLE either way.
REQ-032 DISABLE (exactly one cycle): wr_o=1, addr_rel_o=0, datawr_o=0x00000000; next state DONE.
REQ-033 DONE: done=1 for exactly one cycle, then IDLE.
REQ-034 abort=1 in ENABLE, STREAM, VERIFY_RD or VERIFY_CHK SHALL set error and go to DISABLE next cycle; any pending LOAD write for an accept already taken SHALL still be issued first.
REQ-035 abort=1 in IDLE, DISABLE or DONE SHALL be ignored; start while busy SHALL be ignored.
REQ-036 Simultaneous start and abort in IDLE: start wins.
REQ-037 A change of in_fv after the load has started SHALL NOT pause or alter the load.
REQ-038 wr_o and rd_o SHALL never be high in the same cycle.

Reset
REQ-039 reset_n=0 SHALL force state IDLE and set all outputs to 0, including coef_ready, busy, done, error and loaded_count.
REQ-040 A reset during any state SHALL abandon the load with no DISABLE write; the SCR of the SVM block is reset by the same reset_n.

Verification
REQ-041 NCOEF=4, in_fv=0, start, coefs 5,-3,255,-256 continuous: SCR write 0x2; LOAD writes 0x5, 0xFFFFFFFD, 0xFF, 0xFFFFFF00 back-to-back; rd addr1; datard_i=0xFFFFFF00 gives error=0; SCR write 0x0; done pulse; loaded_count=4.
REQ-042 Same as REQ-041 with coef_valid low for 3 cycles between coefs 2 and 3: 3-cycle wr_o gap; write values unchanged; done asserted 3 cycles later.
REQ-043 datard_i forced to 0 at the check: error=1, DISABLE write still issued, done pulses, error held until the next accepted start.
REQ-044 start while in_fv=1: no bus activity and busy stays 0; start after in_fv falls: load proceeds, and an in_fv rise mid-STREAM has no effect.
REQ-045 abort after 2 accepts: second LOAD write issued, then SCR=0 write, error=1, loaded_count=2, done pulse.
REQ-046 reset_n pulsed low mid-STREAM: all outputs 0 immediately; a new start afterwards gives a full correct load.

Source files
------------

// File: rtl/svcoeff_loader_if.sv
// Coefficient stream and SVM register-bus bundle used by svcoeff_loader.
// master: the loader (consumes coefficients, drives the register bus).
// slave:  the coefficient source / register block side.
interface svcoeff_loader_if #(
  parameter int CWIDTH = 9
);
  logic                     coef_valid;
  logic signed [CWIDTH-1:0] coef_data;
  logic                     coef_ready;
  logic                     addr_rel_o;
  logic                     wr_o;
  logic                     rd_o;
  logic [31:0]              datawr_o;
  logic [31:0]              datard_i;

  modport master (
    input  coef_valid, coef_data, datard_i,
    output coef_ready, addr_rel_o, wr_o, rd_o, datawr_o
  );

  modport slave (
    output coef_valid, coef_data, datard_i,
    input  coef_ready, addr_rel_o, wr_o, rd_o, datawr_o
  );
endinterface

// File: rtl/svcoeff_loader.sv
// SVM coefficient loader: sets the SCR loadcoeff bit, streams NCOEF signed
// coefficients into the LOAD register, reads back the last one to verify it,
// then clears the SCR and pulses done. abort or a read-back mismatch leaves
// a sticky error flag.
module svcoeff_loader #(
  parameter int CWIDTH = 9,
  parameter int NCOEF  = 1088
) (
  input  logic                         clk_proc,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         in_fv,
  svcoeff_loader_if.master             bus,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(NCOEF+1)-1:0]   loaded_count
);

  localparam int          CNT_W    = $clog2(NCOEF + 1);
  localparam logic        ADDR_SCR  = 1'b0;
  localparam logic        ADDR_LOAD = 1'b1;
  localparam logic [31:0] SCR_LOAD  = 32'h0000_0002;
  localparam logic [31:0] SCR_OFF   = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE, ENABLE, STREAM, VERIFY_RD, VERIFY_CHK, DISABLE, DONE
  } state_t;

  state_t                   state;
  logic                     aborting;
  logic signed [CWIDTH-1:0] last_coef;
  logic                     accept;

  function automatic logic [31:0] sext32(input logic signed [CWIDTH-1:0] c);
    logic signed [31:0] w;
    w = 32'(c);
    return w;
  endfunction

  assign bus.coef_ready = (state == STREAM);
  assign accept         = bus.coef_valid & bus.coef_ready;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  // Keep the most recent accepted coefficient for the read-back comparison.
  always_ff @(posedge clk_proc) begin
    if (accept) last_coef <= bus.coef_data;
  end

  // Load sequencer; bus outputs are registered and default to 0 each cycle.
  always_ff @(posedge clk_proc or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      aborting       <= 1'b0;
      error          <= 1'b0;
      loaded_count   <= '0;
      bus.wr_o       <= 1'b0;
      bus.rd_o       <= 1'b0;
      bus.addr_rel_o <= 1'b0;
      bus.datawr_o   <= '0;
    end else begin
      bus.wr_o       <= 1'b0;
      bus.rd_o       <= 1'b0;
      bus.addr_rel_o <= 1'b0;
      bus.datawr_o   <= '0;
      case (state)
        IDLE: begin
          if (start && !in_fv) begin
            state          <= ENABLE;
            error          <= 1'b0;
            loaded_count   <= '0;
            aborting       <= 1'b0;
            bus.wr_o       <= 1'b1;
            bus.addr_rel_o <= ADDR_SCR;
            bus.datawr_o   <= SCR_LOAD;
          end
        end
        ENABLE: begin
          if (abort) begin
            error          <= 1'b1;
            state          <= DISABLE;
            bus.wr_o       <= 1'b1;
            bus.addr_rel_o <= ADDR_SCR;
            bus.datawr_o   <= SCR_OFF;
          end else begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            bus.wr_o       <= 1'b1;
            bus.addr_rel_o <= ADDR_LOAD;
            bus.datawr_o   <= sext32(bus.coef_data);
            if (loaded_count != CNT_W'(NCOEF)) loaded_count <= loaded_count + 1'b1;
          end
          if (abort) begin
            error <= 1'b1;
            if (accept) begin
              // The LOAD write for this accept goes out first; the SCR
              // clear follows from VERIFY_RD without a read-back.
              aborting <= 1'b1;
              state    <= VERIFY_RD;
            end else begin
              state          <= DISABLE;
              bus.wr_o       <= 1'b1;
              bus.addr_rel_o <= ADDR_SCR;
              bus.datawr_o   <= SCR_OFF;
            end
          end else if (accept && loaded_count == CNT_W'(NCOEF - 1)) begin
            state <= VERIFY_RD;
          end
        end
        VERIFY_RD: begin
          // First cycle carries the last LOAD write, second issues the read.
          if (abort || aborting) begin
            error          <= 1'b1;
            aborting       <= 1'b0;
            state          <= DISABLE;
            bus.wr_o       <= 1'b1;
            bus.addr_rel_o <= ADDR_SCR;
            bus.datawr_o   <= SCR_OFF;
          end else if (!bus.rd_o) begin
            bus.rd_o       <= 1'b1;
            bus.addr_rel_o <= ADDR_LOAD;
          end else begin
            state <= VERIFY_CHK;
          end
        end
        VERIFY_CHK: begin
          if (abort || (bus.datard_i != sext32(last_coef))) error <= 1'b1;
          state          <= DISABLE;
          bus.wr_o       <= 1'b1;
          bus.addr_rel_o <= ADDR_SCR;
          bus.datawr_o   <= SCR_OFF;
        end
        DISABLE: state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svcoeff_loader.sv
// Bench for svcoeff_loader with NCOEF=4: directed loads, a scoreboard of
// expected register writes, and a registered read-back responder.
module tb_svcoeff_loader;
  localparam int CW   = 9;
  localparam int NC   = 4;
  localparam int CNTW = $clog2(NC + 1);

  logic            clk_proc = 1'b0;
  logic            reset_n  = 1'b0;
  logic            start    = 1'b0;
  logic            abort    = 1'b0;
  logic            in_fv    = 1'b0;
  logic            busy, done, error;
  logic [CNTW-1:0] loaded_count;

  svcoeff_loader_if #(.CWIDTH(CW)) bus ();

  svcoeff_loader #(.CWIDTH(CW), .NCOEF(NC)) dut (
    .clk_proc     (clk_proc),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .in_fv        (in_fv),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .loaded_count (loaded_count)
  );

  always #5 clk_proc = ~clk_proc;

  int errors = 0;
  int checks = 0;

  logic [32:0] expq[$];
  int          wr_cyc[$];
  int          cyc      = 0;
  int          rd_cnt   = 0;
  int          rd_cyc   = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [31:0] rdval    = 32'h0;

  logic signed [CW-1:0] coefs [4] = '{9'h005, 9'h1FD, 9'h0FF, 9'h100};
  logic [31:0]          exp32 [4] = '{32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_00FF, 32'hFFFF_FF00};

  always @(posedge clk_proc) cyc <= cyc + 1;

  // Register block: read data is registered, valid the cycle after rd_o.
  always @(posedge clk_proc) bus.datard_i <= bus.rd_o ? rdval : 32'h0;

  // Bus monitor: pops the scoreboard on every write, logs reads and done.
  always @(negedge clk_proc) begin
    if (bus.wr_o || bus.rd_o) begin
      checks++;
      assert (!(bus.wr_o && bus.rd_o)) else begin
        errors++;
        $error("FAIL wr_rd_overlap: wr=%0b rd=%0b, required not both high", bus.wr_o, bus.rd_o);
      end
    end
    if (bus.wr_o) begin
      wr_cyc.push_back(cyc);
      checks++;
      assert (expq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: addr=%0b data=%h, required no write", bus.addr_rel_o, bus.datawr_o);
      end
      if (expq.size() != 0) begin
        logic [32:0] e;
        e = expq.pop_front();
        checks++;
        assert ({bus.addr_rel_o, bus.datawr_o} === e) else begin
          errors++;
          $error("FAIL write_value: observed addr=%0b data=%h, expected addr=%0b data=%h",
                 bus.addr_rel_o, bus.datawr_o, e[32], e[31:0]);
        end
      end
    end
    if (bus.rd_o) begin
      rd_cnt++;
      rd_cyc = cyc;
      checks++;
      assert (bus.addr_rel_o === 1'b1) else begin
        errors++;
        $error("FAIL rd_addr: observed=%0b expected=1", bus.addr_rel_o);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One load: n coefficients, optional valid gap, bad read-back, abort after
  // the last coefficient, in_fv rise mid-stream; exp_lat = done - SCR write.
  task automatic do_load(input int n, input int gap_after, input int gap_len, input bit bad,
                         input bit do_abort, input bit fv_rise, input int exp_lat, input bit exp_err);
    int base, d0, r0, guard;
    base  = wr_cyc.size();
    d0    = done_cnt;
    r0    = rd_cnt;
    rdval = bad ? 32'h0 : exp32[3];
    expq.push_back({1'b0, 32'h2});
    @(negedge clk_proc); start = 1'b1;
    @(negedge clk_proc); start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("error_cleared_on_start", 32'(error), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_after) begin
        bus.coef_valid = 1'b0;
        repeat (gap_len) @(negedge clk_proc);
      end
      bus.coef_valid = 1'b1;
      bus.coef_data  = coefs[i];
      guard = 0;
      while (!bus.coef_ready && guard < 20) begin
        @(negedge clk_proc);
        guard++;
      end
      chk("coef_ready_wait", 32'(bus.coef_ready), 32'd1);
      expq.push_back({1'b1, exp32[i]});
      if (i == 0 && fv_rise) in_fv = 1'b1;
      @(negedge clk_proc);
    end
    bus.coef_valid = 1'b0;
    if (do_abort) begin
      abort = 1'b1;
      expq.push_back({1'b0, 32'h0});
      @(negedge clk_proc); abort = 1'b0;
    end else begin
      expq.push_back({1'b0, 32'h0});
    end
    guard = 0;
    while (done_cnt == d0 && guard < 40) begin
      @(posedge clk_proc);
      guard++;
    end
    @(negedge clk_proc);
    chk("done_pulse_count", 32'(done_cnt - d0), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    chk("read_count", 32'(rd_cnt - r0), do_abort ? 32'd0 : 32'd1);
    chk("error_flag", 32'(error), 32'(exp_err));
    chk("loaded_count", 32'(loaded_count), 32'(n));
    chk("done_latency", 32'(done_cyc - wr_cyc[base]), 32'(exp_lat));
    if (gap_after != 0) chk("first_load_timing", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd2);
    if (!do_abort) chk("read_timing", 32'(rd_cyc - wr_cyc[base+n]), 32'd1);
    if (gap_len > 0)
      chk("write_gap", 32'(wr_cyc[base+gap_after+1] - wr_cyc[base+gap_after]), 32'(gap_len + 1));
    in_fv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    repeat (3) @(negedge clk_proc);
    chk("reset_wr", 32'(bus.wr_o), 32'd0);
    chk("reset_coef_ready", 32'(bus.coef_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_count", 32'(loaded_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_proc);

    // Continuous load, correct read-back.
    do_load(4, -1, 0, 1'b0, 1'b0, 1'b0, 9, 1'b0);
    // Three-cycle valid gap between coefficients 2 and 3.
    do_load(4, 2, 3, 1'b0, 1'b0, 1'b0, 12, 1'b0);
    // Read-back returns 0: error set, still disables and pulses done.
    do_load(4, -1, 0, 1'b1, 1'b0, 1'b0, 9, 1'b1);
    repeat (4) @(negedge clk_proc);
    chk("error_sticky", 32'(error), 32'd1);
    n0 = wr_cyc.size();
    abort = 1'b1;
    @(negedge clk_proc); abort = 1'b0;
    repeat (3) @(negedge clk_proc);
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_no_write", 32'(wr_cyc.size() - n0), 32'd0);

    // start ignored while in_fv is high.
    in_fv = 1'b1;
    n0 = wr_cyc.size();
    @(negedge clk_proc); start = 1'b1;
    @(negedge clk_proc); start = 1'b0;
    repeat (4) @(negedge clk_proc);
    chk("fv_start_busy", 32'(busy), 32'd0);
    chk("fv_start_no_write", 32'(wr_cyc.size() - n0), 32'd0);
    chk("fv_start_error_kept", 32'(error), 32'd1);
    in_fv = 1'b0;
    do_load(4, -1, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0);

    // Abort after two accepts.
    do_load(2, -1, 0, 1'b0, 1'b1, 1'b0, 5, 1'b1);

    // Reset mid-stream, then a full load.
    expq.push_back({1'b0, 32'h2});
    @(negedge clk_proc); start = 1'b1;
    @(negedge clk_proc); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.coef_valid = 1'b1;
      bus.coef_data  = coefs[i];
      for (int g = 0; g < 20 && !bus.coef_ready; g++) @(negedge clk_proc);
      expq.push_back({1'b1, exp32[i]});
      @(negedge clk_proc);
    end
    bus.coef_valid = 1'b0;
    @(negedge clk_proc);
    chk("pre_reset_count", 32'(loaded_count), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {bus.wr_o, bus.rd_o, bus.addr_rel_o, bus.coef_ready, busy, done, error},
        32'd0);
    chk("mid_reset_datawr", bus.datawr_o, 32'd0);
    chk("mid_reset_count", 32'(loaded_count), 32'd0);
    chk("mid_reset_sb_drained", 32'(expq.size()), 32'd0);
    @(negedge clk_proc); reset_n = 1'b1;
    @(negedge clk_proc);
    do_load(4, -1, 0, 1'b0, 1'b0, 1'b0, 9, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
